// File: rtl/sync_pkg.sv
// sync_pkg: shared address map and default widths for the synchroniser sampler.
// Revision 1.0
`default_nettype none

package sync_pkg;

  localparam int SYNC_DATA_W   = 16;
  localparam int SYNC_ADDR_W   = 8;
  localparam int SAMPLER_NREGS = 2;

  // Sampler configuration register map (offsets from the bank base address)
  localparam logic [SYNC_ADDR_W-1:0] NUMSAMPLESREG   = 8'h00;
  localparam logic [SYNC_ADDR_W-1:0] SUBVALUEREG     = 8'h01;
  localparam logic [SYNC_ADDR_W-1:0] SAMPLERCTRLREG  = 8'h02;
  localparam logic [SYNC_ADDR_W-1:0] SAMPLERTHRSHREG = 8'h03;

  // Register index width, never narrower than one bit.
  function automatic int sampler_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/samplerregs_cell.sv
// samplerregs_cell: one shadow/active register pair; shadow storage only with SAMPLERREGS_SHADOW_EN.
// Revision 1.0
`default_nettype none

module samplerregs_cell #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_xfer,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_shadow,
  output logic [DATA_W-1:0] o_active
);

  logic [DATA_W-1:0] active_d, active_q;

`ifdef SAMPLERREGS_SHADOW_EN
  logic [DATA_W-1:0] shadow_d, shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (i_we) shadow_d = i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= RST_VAL;
    else        shadow_q <= shadow_d;
  end

  assign o_shadow = shadow_q;
`else
  // Without a shadow the "shadow" view is the active register itself.
  assign o_shadow = active_q;
`endif

  // A write takes priority; it only reaches here directly when there is no shadow.
  always_comb begin
    active_d = active_q;
    if (i_xfer) active_d = o_shadow;
`ifndef SAMPLERREGS_SHADOW_EN
    if (i_we)   active_d = i_wdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_q <= RST_VAL;
    else        active_q <= active_d;
  end

  assign o_active = active_q;

endmodule

`default_nettype wire

// File: rtl/samplerregs_bank.sv
// samplerregs_bank: NUM_REGS-wide sampler config bank; SAMPLERREGS_SHADOW_EN selects double buffering.
// Revision 1.0
`default_nettype none

module samplerregs_bank
  import sync_pkg::*;
#(
  parameter int                           NUM_REGS  = SAMPLER_NREGS,
  parameter int                           DATA_W    = SYNC_DATA_W,
  parameter int                           ADDR_W    = SYNC_ADDR_W,
  parameter int                           BASE_ADDR = 0,
  parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data_in,
  output logic [DATA_W-1:0]            cfg_data_out,
  output logic                         cfg_hit,
  input  logic                         sync_strobe,
  output logic [NUM_REGS*DATA_W-1:0]   reg_data_out,
  output logic                         upd_pending,
  output logic                         upd_pulse
);

  localparam int                IDX_W = sampler_idx_w(NUM_REGS);
  localparam logic [ADDR_W:0]   C_LO  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_NUM = ADDR_W'(NUM_REGS);

  logic [ADDR_W:0]   diff;
  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic [NUM_REGS-1:0] wr_en;
  logic              xfer;
  logic [DATA_W-1:0] shadow_w [NUM_REGS];

  logic [DATA_W-1:0] cfg_data_out_d, cfg_data_out_q;
  logic              cfg_hit_d, cfg_hit_q;
  logic              upd_pulse_d, upd_pulse_q;

  // The borrow out of the subtraction flags addresses below the base.
  always_comb begin
    diff = {1'b0, cfg_addr} - C_LO;
    hit  = !diff[ADDR_W] && (diff[ADDR_W-1:0] < C_NUM);
    idx  = diff[IDX_W-1:0];
  end

  always_comb begin
    wr_en          = '0;
    cfg_data_out_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit && (idx == IDX_W'(i))) begin
        wr_en[i]       = cfg_we;
        cfg_data_out_d = shadow_w[i];
      end
    end
    cfg_hit_d = hit;
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
      samplerregs_cell #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL[gi*DATA_W +: DATA_W])
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (wr_en[gi]),
        .i_xfer   (xfer),
        .i_wdata  (cfg_data_in),
        .o_shadow (shadow_w[gi]),
        .o_active (reg_data_out[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

`ifdef SAMPLERREGS_SHADOW_EN
  logic upd_pending_d, upd_pending_q;

  // A write landing alongside a transfer keeps the flag set for the next strobe.
  always_comb begin
    xfer          = sync_strobe && upd_pending_q;
    upd_pulse_d   = xfer;
    upd_pending_d = upd_pending_q;
    if (xfer)   upd_pending_d = 1'b0;
    if (|wr_en) upd_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_pending_q <= 1'b0;
    else        upd_pending_q <= upd_pending_d;
  end

  assign upd_pending = upd_pending_q;
`else
  // Actives reload from themselves on a strobe, so the strobe is functionally ignored.
  always_comb begin
    xfer        = sync_strobe;
    upd_pulse_d = |wr_en;
  end

  assign upd_pending = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_data_out_q <= '0;
      cfg_hit_q      <= 1'b0;
      upd_pulse_q    <= 1'b0;
    end else begin
      cfg_data_out_q <= cfg_data_out_d;
      cfg_hit_q      <= cfg_hit_d;
      upd_pulse_q    <= upd_pulse_d;
    end
  end

  assign cfg_data_out = cfg_data_out_q;
  assign cfg_hit      = cfg_hit_q;
  assign upd_pulse    = upd_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_samplerregs_bank.sv
// tb_samplerregs_bank: directed self-checking bench for samplerregs_bank (BASE_ADDR=0x10, two registers).
// Revision 1.0
`default_nettype none

module tb_samplerregs_bank;

  localparam logic [31:0] RST = {16'h0005, 16'h0010};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = 8'h00;
  logic [15:0] cfg_data_in = 16'h0000;
  logic [15:0] cfg_data_out;
  logic        cfg_hit;
  logic        sync_strobe = 1'b0;
  logic [31:0] reg_data_out;
  logic        upd_pending;
  logic        upd_pulse;

  int tests = 0;
  int fails = 0;

  samplerregs_bank #(
    .NUM_REGS  (2),
    .DATA_W    (16),
    .ADDR_W    (8),
    .BASE_ADDR (16),
    .RST_VAL   (RST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data_in  (cfg_data_in),
    .cfg_data_out (cfg_data_out),
    .cfg_hit      (cfg_hit),
    .sync_strobe  (sync_strobe),
    .reg_data_out (reg_data_out),
    .upd_pending  (upd_pending),
    .upd_pulse    (upd_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_we = 1'b0;
    sync_strobe = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    tests++; if (reg_data_out !== RST) begin fails++; $display("FAIL reset_regs: got %h exp %h", reg_data_out, RST); end
    tests++; if (upd_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b exp 0", upd_pending); end
    tests++; if (upd_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b exp 0", upd_pulse); end
    tests++; if (cfg_hit !== 1'b0 || cfg_data_out !== 16'h0) begin fails++; $display("FAIL reset_rd: got hit %b data %h exp 0 0000", cfg_hit, cfg_data_out); end
    step(); step();
    rst_n = 1'b1;
    cfg_addr = 8'h11;
    step();
    tests++; if (cfg_data_out !== 16'h0005 || cfg_hit !== 1'b1) begin fails++; $display("FAIL reset_rd1: got hit %b data %h exp 1 0005", cfg_hit, cfg_data_out); end
    cfg_addr = 8'h10;
    step();
    tests++; if (cfg_data_out !== 16'h0010) begin fails++; $display("FAIL reset_rd0: got %h exp 0010", cfg_data_out); end
  endtask

  task automatic test_out_of_window();
    logic [7:0] addrs [2];
    addrs[0] = 8'h12;
    addrs[1] = 8'h0F;
    for (int k = 0; k < 2; k++) begin
      cfg_addr = addrs[k]; cfg_data_in = 16'hDEAD; cfg_we = 1'b1;
      step();
      idle();
      tests++; if (cfg_hit !== 1'b0 || cfg_data_out !== 16'h0) begin fails++; $display("FAIL oow_rd %h: got hit %b data %h exp 0 0000", addrs[k], cfg_hit, cfg_data_out); end
      tests++; if (reg_data_out !== RST || upd_pulse !== 1'b0 || upd_pending !== 1'b0) begin fails++; $display("FAIL oow_state %h: got regs %h pulse %b pend %b exp %h 0 0", addrs[k], reg_data_out, upd_pulse, upd_pending, RST); end
    end
    cfg_addr = 8'h11;
    step();
    tests++; if (cfg_data_out !== 16'h0005) begin fails++; $display("FAIL oow_rd1: got %h exp 0005", cfg_data_out); end
    sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (upd_pulse !== 1'b0 || reg_data_out !== RST) begin fails++; $display("FAIL idle_strobe: got pulse %b regs %h exp 0 %h", upd_pulse, reg_data_out, RST); end
  endtask

`ifdef SAMPLERREGS_SHADOW_EN
  task automatic test_write_strobe();
    cfg_addr = 8'h11; cfg_data_in = 16'h1234; cfg_we = 1'b1;
    step();
    idle();
    tests++; if (upd_pending !== 1'b1 || reg_data_out !== RST) begin fails++; $display("FAIL ws_pend: got pend %b regs %h exp 1 %h", upd_pending, reg_data_out, RST); end
    step();
    tests++; if (cfg_data_out !== 16'h1234) begin fails++; $display("FAIL ws_shadow_rd: got %h exp 1234", cfg_data_out); end
    sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (reg_data_out !== 32'h1234_0010 || upd_pulse !== 1'b1 || upd_pending !== 1'b0) begin fails++; $display("FAIL ws_xfer: got regs %h pulse %b pend %b exp 12340010 1 0", reg_data_out, upd_pulse, upd_pending); end
    step();
    tests++; if (upd_pulse !== 1'b0) begin fails++; $display("FAIL ws_pulse_len: got %b exp 0", upd_pulse); end
  endtask

  task automatic test_write_during_strobe();
    cfg_addr = 8'h11; cfg_data_in = 16'h1111; cfg_we = 1'b1;
    step();
    cfg_data_in = 16'hAAAA; sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (reg_data_out !== 32'h1111_0010 || upd_pending !== 1'b1 || upd_pulse !== 1'b1) begin fails++; $display("FAIL wds_xfer: got regs %h pend %b pulse %b exp 11110010 1 1", reg_data_out, upd_pending, upd_pulse); end
    step();
    sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (reg_data_out !== 32'hAAAA_0010 || upd_pending !== 1'b0) begin fails++; $display("FAIL wds_next: got regs %h pend %b exp AAAA0010 0", reg_data_out, upd_pending); end
  endtask

  task automatic test_last_write_wins();
    cfg_addr = 8'h10; cfg_we = 1'b1; cfg_data_in = 16'h0101;
    step();
    cfg_data_in = 16'h0202;
    step();
    idle(); sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (reg_data_out !== 32'hAAAA_0202) begin fails++; $display("FAIL lww: got %h exp AAAA0202", reg_data_out); end
  endtask

  task automatic test_reset_mid();
    cfg_addr = 8'h10; cfg_data_in = 16'h7777; cfg_we = 1'b1;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    tests++; if (reg_data_out !== RST || upd_pending !== 1'b0) begin fails++; $display("FAIL rmid: got regs %h pend %b exp %h 0", reg_data_out, upd_pending, RST); end
    @(negedge clk); rst_n = 1'b1;
    sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (upd_pulse !== 1'b0 || reg_data_out !== RST) begin fails++; $display("FAIL rmid_strobe: got pulse %b regs %h exp 0 %h", upd_pulse, reg_data_out, RST); end
  endtask
`else
  task automatic test_direct_write();
    cfg_addr = 8'h10; cfg_data_in = 16'h00FF; cfg_we = 1'b1;
    step();
    idle();
    tests++; if (reg_data_out !== 32'h0005_00FF || upd_pulse !== 1'b1 || upd_pending !== 1'b0) begin fails++; $display("FAIL dw: got regs %h pulse %b pend %b exp 000500FF 1 0", reg_data_out, upd_pulse, upd_pending); end
    step();
    tests++; if (upd_pulse !== 1'b0 || cfg_data_out !== 16'h00FF) begin fails++; $display("FAIL dw_rd: got pulse %b data %h exp 0 00FF", upd_pulse, cfg_data_out); end
    sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (upd_pulse !== 1'b0 || reg_data_out !== 32'h0005_00FF) begin fails++; $display("FAIL dw_strobe: got pulse %b regs %h exp 0 000500FF", upd_pulse, reg_data_out); end
  endtask

  task automatic test_back_to_back();
    cfg_addr = 8'h11; cfg_we = 1'b1; cfg_data_in = 16'hBEEF;
    step();
    tests++; if (reg_data_out !== 32'hBEEF_00FF || upd_pulse !== 1'b1) begin fails++; $display("FAIL b2b_1: got regs %h pulse %b exp BEEF00FF 1", reg_data_out, upd_pulse); end
    cfg_data_in = 16'hCAFE; sync_strobe = 1'b1;
    step();
    idle();
    tests++; if (reg_data_out !== 32'hCAFE_00FF || upd_pulse !== 1'b1) begin fails++; $display("FAIL b2b_2: got regs %h pulse %b exp CAFE00FF 1", reg_data_out, upd_pulse); end
    step();
    tests++; if (cfg_data_out !== 16'hCAFE || upd_pulse !== 1'b0) begin fails++; $display("FAIL b2b_rd: got data %h pulse %b exp CAFE 0", cfg_data_out, upd_pulse); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    tests++; if (reg_data_out !== RST || upd_pulse !== 1'b0 || cfg_data_out !== 16'h0) begin fails++; $display("FAIL rmid: got regs %h pulse %b data %h exp %h 0 0000", reg_data_out, upd_pulse, cfg_data_out, RST); end
    @(negedge clk); rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_out_of_window();
`ifdef SAMPLERREGS_SHADOW_EN
    test_write_strobe();
    test_write_during_strobe();
    test_last_write_wins();
    test_reset_mid();
`else
    test_direct_write();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/samplerregs_bank.md
# samplerregs_bank

Parametrised configuration register bank for the synchroniser sampler, generalising the fixed two-register sampler bank to `NUM_REGS` registers at a contiguous address window. Each register has a CPU-side shadow copy and a sampler-side active copy. Shadows are transferred atomically to the active copies at a sampler-supplied sync point, so the sampler never sees a half-updated configuration. The block sits between the configuration bus decoder and the sampler/control datapath; readback is registered.

## Interface
Parameters:
- `NUM_REGS`, 2: number of registers in the bank (1..16).
- `DATA_W`, 16: register width; matches the config data bus width.
- `ADDR_W`, 8: config address width.
- `BASE_ADDR`, 0: address of register 0; register i decodes at `BASE_ADDR+i`.
- `RST_VAL`, all zeros: `NUM_REGS*DATA_W` reset vector; register i resets to slice `[i*DATA_W +: DATA_W]`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_we` in 1: write strobe, one write per asserted cycle.
- `cfg_addr` in `ADDR_W`: config address.
- `cfg_data_in` in `DATA_W`: write data.
- `cfg_data_out` out `DATA_W`: registered readback of the addressed shadow.
- `cfg_hit` out 1: registered; 1 when the previous-cycle address hit the window.
- `sync_strobe` in 1: sampler sync point, e.g. frame start; single-cycle pulse.
- `reg_data_out` out `NUM_REGS*DATA_W`: active values, register i at slice i.
- `upd_pending` out 1: at least one shadow has been written since the last transfer.
- `upd_pulse` out 1: one-cycle pulse in the cycle after a transfer.

## Operation
- Decode: `hit = (cfg_addr >= BASE_ADDR) && (cfg_addr < BASE_ADDR+NUM_REGS)`. Index is `cfg_addr-BASE_ADDR`, truncated to `$clog2(NUM_REGS)` bits (minimum 1).
- Write: when `cfg_we && hit`, the shadow at the index takes `cfg_data_in` and `upd_pending` is set. Writes outside the window are ignored.
- Readback: every cycle, `cfg_data_out` takes the shadow at the index if `hit`, else 0. `cfg_hit` takes `hit`. Reads are side-effect free.
- Transfer: on `sync_strobe && upd_pending`, all active copies take their pre-edge shadow values, `upd_pending` clears and `upd_pulse` is asserted for one cycle.
- A `sync_strobe` with `upd_pending=0` does nothing and gives no pulse.
- Simultaneous write and transfer in the same cycle:
  - The transfer uses the pre-edge shadows.
  - The write lands in its shadow.
  - `upd_pending` stays 1, so the new value is applied at the next strobe.
- Repeated writes to one register before a strobe: the last write wins.
- Reset, including mid-operation: shadows and actives take `RST_VAL`; `cfg_data_out`=0, `cfg_hit`=0, `upd_pending`=0, `upd_pulse`=0. Any pending update is lost.

## Timing
- Write to shadow readback: write at edge N, read address presented in cycle N+1, data valid after edge N+1.
- Readback latency is 1 cycle from the address.
- Strobe at edge N: `reg_data_out` and `upd_pulse` change at edge N. `upd_pulse` is high for exactly cycle N..N+1.
- `reg_data_out` changes only at transfer edges or at reset; it is glitch-free.
- No combinational path from any input to any output.

## Configuration
- `SAMPLERREGS_SHADOW_EN` defined: double-buffered behaviour as described above.
- Undefined:
  - No shadow storage.
  - A write updates the active register directly at the write edge.
  - `upd_pulse` fires in the cycle after each in-window write.
  - `upd_pending` is tied to 0 and `sync_strobe` is ignored.
  - Readback returns the active value.

## Structure
- Shared package `sync_pkg`: register address constants (`NUMSAMPLESREG`, `SUBVALUEREG`, new entries), default `DATA_W`/`ADDR_W`, and a `SAMPLER_NREGS` constant.
- Sub-module `samplerregs_cell`:
  - one shadow/active pair with reset value;
  - inputs: write enable and transfer enable;
  - generated `NUM_REGS` times.
- Top level holds the decode, the readback register and the pending/pulse flags.

## Test plan
- Reset with `RST_VAL={16'h0005,16'h0010}`: `reg_data_out`=0x0005_0010, `upd_pending`=0; readback of reg1 = 0x0005 with `cfg_hit`=1.
- Write 0x1234 to `BASE_ADDR+1`: pending=1, `reg_data_out` unchanged. Strobe: reg1 active=0x1234, one `upd_pulse`, pending=0.
- Write 0xAAAA in the same cycle as a strobe, with a prior pending 0x1111: active=0x1111, pending stays 1. Next strobe: active=0xAAAA.
- Write and read at `BASE_ADDR+NUM_REGS`: no state change, `cfg_data_out`=0, `cfg_hit`=0. Strobe with no pending: no pulse.
- Assert `rst_n` low between a write and the strobe: active=`RST_VAL`, pending=0; the following strobe gives no pulse.
- Build without `SAMPLERREGS_SHADOW_EN`: write 0x00FF to reg0 updates `reg_data_out` at the next edge with `upd_pulse`; `sync_strobe` has no effect.
